// File: rtl/fb_defines.sv
// Shared architectural constants for the fb register-file family.
// Register count is derived from the architectural address width so the two cannot disagree.
package fb_defines;

    localparam int ARCH_AW  = 5;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 1 << ARCH_AW;

endpackage

// File: rtl/fb_scoreboard.sv
// Busy-bit scoreboard: one bit per register, set by alloc, cleared by writes, wiped by flush.
// Lookup is combinational; state updates on the rising edge; no backpressure.
module fb_scoreboard
    import fb_defines::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NRD*AW-1:0] raddr,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              alloc_valid,
    input  logic [AW-1:0]     alloc_addr,
    input  logic              flush,
    output logic [NRD-1:0]    rbusy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Write clears first so a same-cycle alloc re-marks the register for its new producer.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NWR; w++) begin
            if (we[w]) begin
                busy_d[waddr[w*AW +: AW]] = 1'b0;
            end
        end
        if (flush) begin
            busy_d = '0;
        end else if (alloc_valid) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        logic [AW-1:0] ra;
        logic          hit;
        rbusy = '0;
        for (int p = 0; p < NRD; p++) begin
            ra  = raddr[p*AW +: AW];
            hit = 1'b0;
`ifdef FB_REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && (waddr[w*AW +: AW] == ra) && (ra != '0)) begin
                    hit = 1'b1;
                end
            end
`endif
            // A forwarded write hides the old busy bit; only a same-cycle alloc keeps it set.
            rbusy[p] = reset_n & (hit ? busy_d[ra] : busy_q[ra]);
        end
    end

endmodule

// File: rtl/fb_regfile_mp.sv
// Multi-port register file with x0 hardwired to zero and a busy scoreboard; build option FB_REGFILE_BYPASS_EN.
// Reads are combinational, writes commit on the rising edge (highest port wins); no backpressure.
module fb_regfile_mp
    import fb_defines::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic                alloc_valid,
    input  logic [AW-1:0]       alloc_addr,
    input  logic                flush
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        for (int w = 0; w < NWR; w++) begin
            if (we[w]) begin
                regs_d[waddr[w*AW +: AW]] = wdata[w*XLEN +: XLEN];
            end
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] val;
        rdata = '0;
        for (int p = 0; p < NRD; p++) begin
            ra  = raddr[p*AW +: AW];
            val = regs_q[ra];
`ifdef FB_REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (we[w] && (waddr[w*AW +: AW] == ra) && (ra != '0)) begin
                    val = wdata[w*XLEN +: XLEN];
                end
            end
`endif
            rdata[p*XLEN +: XLEN] = reset_n ? val : '0;
        end
    end

    fb_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .NWR  (NWR),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .raddr       (raddr),
        .we          (we),
        .waddr       (waddr),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .flush       (flush),
        .rbusy       (rbusy)
    );

endmodule

// File: tb/tb_fb_regfile_mp.sv
// Bench for fb_regfile_mp: directed corner cases then random traffic against an array-based reference model.
module tb_fb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rbusy;
    logic [NWR-1:0]      we;
    logic [NWR*AW-1:0]   waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic                alloc_valid;
    logic [AW-1:0]       alloc_addr;
    logic                flush;

    fb_regfile_mp #(
        .XLEN (XLEN), .NREG (NREG), .NRD (NRD), .NWR (NWR)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .raddr       (raddr),
        .rdata       (rdata),
        .rbusy       (rbusy),
        .we          (we),
        .waddr       (waddr),
        .wdata       (wdata),
        .alloc_valid (alloc_valid),
        .alloc_addr  (alloc_addr),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        string               name;
        logic [NRD*XLEN-1:0] rd;
        logic [NRD-1:0]      rb;
    } exp_t;

    exp_t        expq[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] mregs [NREG];
    bit          mbusy [NREG];

    // Stimulus is applied just after each rising edge, so every falling edge sees one settled cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                total++;
                if (rdata !== e.rd) begin
                    bad++;
                    $display("FAIL %s rdata got=%h want=%h", e.name, rdata, e.rd);
                end
                total++;
                if (rbusy !== e.rb) begin
                    bad++;
                    $display("FAIL %s rbusy got=%b want=%b", e.name, rbusy, e.rb);
                end
            end
        end
    end

    task automatic drive(input string nm, input bit rst, input logic [1:0] w_en,
                         input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input bit av, input logic [4:0] aa, input bit fl,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        exp_t        e;
        logic [4:0]  ra  [NRD];
        logic [4:0]  wa  [NWR];
        logic [31:0] wd  [NWR];
        logic [31:0] d;
        bit          b;
        bit          hit;
        @(posedge clk);
        #1;
        reset_n     = rst;
        we          = w_en;
        waddr       = {wa1, wa0};
        wdata       = {wd1, wd0};
        alloc_valid = av;
        alloc_addr  = aa;
        flush       = fl;
        raddr       = {ra1, ra0};
        ra[0] = ra0; ra[1] = ra1;
        wa[0] = wa0; wa[1] = wa1;
        wd[0] = wd0; wd[1] = wd1;
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                mregs[r] = '0;
                mbusy[r] = 1'b0;
            end
        end
        e.name = nm;
        e.rd   = '0;
        e.rb   = '0;
        for (int p = 0; p < NRD; p++) begin
            d   = mregs[ra[p]];
            b   = mbusy[ra[p]];
            hit = 1'b0;
`ifdef FB_REGFILE_BYPASS_EN
            for (int w = 0; w < NWR; w++) begin
                if (w_en[w] && wa[w] == ra[p] && ra[p] != 0) begin
                    d   = wd[w];
                    hit = 1'b1;
                end
            end
            if (hit) b = av && !fl && (aa == ra[p]);
`endif
            if (!rst || ra[p] == 0) begin
                d = '0;
                b = 1'b0;
            end
            e.rd[p*XLEN +: XLEN] = d;
            e.rb[p]              = b;
        end
        expq.push_back(e);
        // Reference update for the coming edge.
        if (rst) begin
            for (int w = 0; w < NWR; w++) begin
                if (w_en[w]) begin
                    if (wa[w] != 0) mregs[wa[w]] = wd[w];
                    mbusy[wa[w]] = 1'b0;
                end
            end
            if (fl) begin
                for (int r = 0; r < NREG; r++) mbusy[r] = 1'b0;
            end else if (av && aa != 0) begin
                mbusy[aa] = 1'b1;
            end
        end
    endtask

    task automatic idle(input string nm, input logic [4:0] ra0, input logic [4:0] ra1);
        drive(nm, 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, ra0, ra1);
    endtask

    initial begin
        reset_n = 1'b0; we = '0; waddr = '0; wdata = '0;
        alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0; raddr = '0;

        drive("reset_state", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd31);
        drive("reset_ignores", 1'b0, 2'b01, 5'd6, 32'hCAFE, 5'd0, 32'h0, 1'b1, 5'd6, 1'b0, 5'd6, 5'd6);
        idle("post_reset", 5'd6, 5'd1);

        drive("x0_write", 1'b1, 2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
        idle("x0_after", 5'd0, 5'd0);

        drive("conflict", 1'b1, 2'b11, 5'd7, 32'hAAAA, 5'd7, 32'h5555, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
        idle("conflict_after", 5'd7, 5'd7);

        drive("alloc9", 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        drive("write9", 1'b1, 2'b01, 5'd9, 32'h42, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd1);
        drive("alloc_write9", 1'b1, 2'b10, 5'd0, 32'h0, 5'd9, 32'h43, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9);
        idle("busy_kept9", 5'd9, 5'd9);

        drive("seed3", 1'b1, 2'b01, 5'd3, 32'h11, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd3);
        drive("bypass3", 1'b1, 2'b01, 5'd3, 32'h77, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd3);
        idle("after3", 5'd3, 5'd3);

        drive("alloc4", 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0, 5'd4, 5'd8);
        drive("alloc8", 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd8, 1'b0, 5'd4, 5'd8);
        drive("flush", 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd10, 1'b1, 5'd4, 5'd8);
        idle("flush_after", 5'd4, 5'd10);
        idle("flush_after8", 5'd8, 5'd9);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] a0, a1, aa, r0, r1;
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            aa = 5'($urandom_range(0, 7));
            r0 = 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 7));
            drive("random", 1'b1, 2'($urandom_range(0, 3)), a0, $urandom, a1, $urandom,
                  1'($urandom_range(0, 1)), aa, ($urandom_range(0, 15) == 0), r0, r1);
        end

        drive("write5", 1'b1, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
        idle("read5", 5'd5, 5'd5);
        drive("async_reset", 1'b0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
        idle("after_reset5", 5'd5, 5'd6);

        for (int i = 0; i < 20 && expq.size() > 0; i++) @(posedge clk);
        if (expq.size() > 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
